vc_vr_converter_mc: RTL and testbench

//  Multi-channel valid/credit -> valid/ready converter with arbitration.
//  - NUM_CH independent credit-flow senders each own a CREDIT_NUM-deep buffer.
//  - Buffered beats are merged onto one valid/ready master port by a round-robin arbiter.
//  - Each beat carries its source channel ID.
//  - Sits at an interconnect ingress, in front of valid/ready fabric logic.

---
 rtl/vc_vr_pkg.sv | 14 +
 rtl/fifo.sv | 53 +++++
 rtl/vc_vr_converter_mc.sv | 158 +++++++++++++++
 tb/tb_vc_vr_converter_mc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_vr_pkg.sv
// Shared types for the multi-channel valid/credit to valid/ready converter.
package vc_vr_pkg;

  localparam int unsigned NUM_CH_DEF   = 4;
  localparam int unsigned ID_WIDTH_DEF = $clog2(NUM_CH_DEF);

  typedef logic [ID_WIDTH_DEF-1:0] ch_id_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo.sv
// Small synchronous FIFO with registered head; a push on a full FIFO is accepted
// only when a pop frees the slot in the same cycle.
module fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LENGTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int unsigned PTR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned CNT_W = $clog2(LENGTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [LENGTH];
  logic [PTR_W-1:0]      r_rd;
  logic [PTR_W-1:0]      r_wr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_pop;
  logic                  w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNT_W'(LENGTH));
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_pop)
        r_rd <= (r_rd == PTR_W'(LENGTH - 1)) ? '0 : r_rd + PTR_W'(1);
      if (w_push)
        r_wr <= (r_wr == PTR_W'(LENGTH - 1)) ? '0 : r_wr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/vc_vr_converter_mc.sv
// Merges NUM_CH credit-flow input channels onto one valid/ready port through
// per-channel buffers and a round-robin arbiter that locks on backpressure.
module vc_vr_converter_mc
  import vc_vr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CREDIT_NUM = 2,
  parameter int unsigned NUM_CH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_CH-1:0]            s_valid_i,
  output logic [NUM_CH-1:0]            s_credit_o,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic [$clog2(NUM_CH)-1:0]    m_id_o,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [NUM_CH-1:0]            ovf_o
);

  localparam int unsigned ID_WIDTH = $clog2(NUM_CH);
  localparam int unsigned CW       = $clog2(CREDIT_NUM + 1);

  logic [DATA_WIDTH-1:0] w_head [NUM_CH];
  logic [NUM_CH-1:0]     w_empty;
  logic [NUM_CH-1:0]     w_full;
  logic [NUM_CH-1:0]     w_nonempty;
  logic [NUM_CH-1:0]     w_pop;

  logic [CW-1:0]         r_owed [NUM_CH];
  logic [CW:0]           w_owed_nxt [NUM_CH];
  logic [NUM_CH-1:0]     r_credit;
  logic [NUM_CH-1:0]     r_ovf;

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ID_WIDTH-1:0]   w_rr_nxt;
  logic [ID_WIDTH-1:0]   r_lock_id;
  logic [ID_WIDTH-1:0]   w_lock_nxt;
  logic [ID_WIDTH-1:0]   w_rr_grant;
  logic [ID_WIDTH-1:0]   w_grant;
  logic                  w_found;
  logic                  w_hs;
  int unsigned           w_idx;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .LENGTH    (CREDIT_NUM)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_push (s_valid_i[c]),
      .i_data (s_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .i_pop  (w_pop[c]),
      .o_data (w_head[c]),
      .o_empty(w_empty[c]),
      .o_full (w_full[c])
    );
  end

  assign w_nonempty = ~w_empty;
  assign m_valid_o  = |w_nonempty;
  assign w_grant    = (r_state == ARB_LOCKED) ? r_lock_id : w_rr_grant;
  assign m_id_o     = w_grant;
  assign m_data_o   = w_head[w_grant];
  assign w_hs       = m_valid_o && m_ready_i;
  assign s_credit_o = r_credit;
  assign ovf_o      = r_ovf;

  always_comb begin
    w_pop = '0;
    if (w_hs)
      w_pop[w_grant] = 1'b1;
  end

  // First non-empty channel at or after rr_ptr, wrapping explicitly for any NUM_CH.
  always_comb begin
    w_rr_grant = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_CH)
        w_idx = w_idx - NUM_CH;
      if (!w_found && w_nonempty[ID_WIDTH'(w_idx)]) begin
        w_found    = 1'b1;
        w_rr_grant = ID_WIDTH'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_id;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (m_valid_o && !m_ready_i) begin
          w_state_nxt = ARB_LOCKED;
          w_lock_nxt  = w_grant;
        end
      end
      ARB_LOCKED: begin
        if (w_hs)
          w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
    if (w_hs)
      w_rr_nxt = (w_grant == ID_WIDTH'(NUM_CH - 1)) ? '0 : w_grant + ID_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_lock_id <= w_lock_nxt;
    end
  end

  // An issued credit and a pop in the same cycle cancel out.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      w_owed_nxt[c] = {1'b0, r_owed[c]} - (CW+1)'(r_owed[c] != '0) + (CW+1)'(w_pop[c]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= '0;
      r_ovf    <= '0;
      for (int c = 0; c < NUM_CH; c++)
        r_owed[c] <= CW'(CREDIT_NUM);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_credit[c] <= (r_owed[c] != '0);
        r_owed[c]   <= CW'(w_owed_nxt[c]);
        if (s_valid_i[c] && w_full[c] && !w_pop[c])
          r_ovf[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++)
        assert (w_owed_nxt[c] <= (CW+1)'(CREDIT_NUM))
          else $error("owed credit counter exceeds CREDIT_NUM on channel %0d", c);
    end
  end

endmodule

// File: tb/tb_vc_vr_converter_mc.sv
// Directed bench for vc_vr_converter_mc with NUM_CH=4, CREDIT_NUM=2, DATA_WIDTH=8.
module tb_vc_vr_converter_mc;

  logic        clk;
  logic        rst;
  logic [31:0] s_data_i;
  logic [3:0]  s_valid_i;
  logic [3:0]  s_credit_o;
  logic [7:0]  m_data_o;
  logic [1:0]  m_id_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [3:0]  ovf_o;

  int checks;
  int errors;

  vc_vr_converter_mc #(
    .DATA_WIDTH(8),
    .CREDIT_NUM(2),
    .NUM_CH    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_credit_o(s_credit_o),
    .m_data_o  (m_data_o),
    .m_id_o    (m_id_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .ovf_o     (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    s_valid_i[ch]       = 1'b1;
    s_data_i[ch*8 +: 8] = d;
  endtask

  // Counts credit pulses over n cycles and checks 2 consecutive pulses per channel.
  task automatic count_credits(input int n, input string tag);
    int cnt   [4];
    int first [4];
    bit consec[4];
    for (int c = 0; c < 4; c++) begin
      cnt[c] = 0; first[c] = -1; consec[c] = 1'b0;
    end
    for (int t = 0; t < n; t++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        if (s_credit_o[c]) begin
          if (cnt[c] == 1 && first[c] == t - 1) consec[c] = 1'b1;
          if (first[c] < 0) first[c] = t;
          cnt[c]++;
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (cnt[c] !== 2) begin
        errors++;
        $display("FAIL %s credit count ch%0d: got %0d want 2", tag, c, cnt[c]);
      end
      checks++;
      if (consec[c] !== 1'b1) begin
        errors++;
        $display("FAIL %s credits consecutive ch%0d: got %0d want 1", tag, c, consec[c]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid_i = '0; s_data_i = '0; m_ready_i = 1'b0;
    tick(); tick();
    checks++;
    if (m_valid_o !== 1'b0 || ovf_o !== 4'h0 || s_credit_o !== 4'h0) begin
      errors++;
      $display("FAIL reset outputs: valid=%b ovf=%h credit=%h want 0/0/0", m_valid_o, ovf_o, s_credit_o);
    end
    rst = 1'b0;
    count_credits(6, "reset");
    checks++;
    if (m_valid_o !== 1'b0 || ovf_o !== 4'h0) begin
      errors++;
      $display("FAIL reset release: valid=%b ovf=%h want 0/0", m_valid_o, ovf_o);
    end
  endtask

  task automatic test_single();
    m_ready_i = 1'b1;
    push(2, 8'hA5);
    tick();
    s_valid_i = '0;
    checks++;
    if (m_valid_o !== 1'b1 || m_id_o !== 2'd2 || m_data_o !== 8'hA5) begin
      errors++;
      $display("FAIL single beat: valid=%b id=%0d data=%h want 1/2/a5", m_valid_o, m_id_o, m_data_o);
    end
    tick();
    checks++;
    if (m_valid_o !== 1'b0 || s_credit_o !== 4'h0) begin
      errors++;
      $display("FAIL single after hs: valid=%b credit=%h want 0/0", m_valid_o, s_credit_o);
    end
    tick();
    checks++;
    if (s_credit_o !== 4'b0100) begin
      errors++;
      $display("FAIL single credit pulse: got %h want 4", s_credit_o);
    end
    tick();
    checks++;
    if (s_credit_o !== 4'h0) begin
      errors++;
      $display("FAIL single credit end: got %h want 0", s_credit_o);
    end
  endtask

  task automatic test_round_robin();
    int cnt[4];
    logic [7:0] exp_d;
    rst = 1'b1; m_ready_i = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) push(c, 8'(16 * c + k));
      tick();
    end
    s_valid_i = '0;
    m_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int i = 0; i < 8; i++) begin
      exp_d = 8'(16 * (i % 4) + i / 4);
      checks++;
      if (m_valid_o !== 1'b1 || m_id_o !== 2'(i % 4) || m_data_o !== exp_d) begin
        errors++;
        $display("FAIL rr beat %0d: valid=%b id=%0d data=%h want 1/%0d/%h",
                 i, m_valid_o, m_id_o, m_data_o, i % 4, exp_d);
      end
      tick();
      for (int c = 0; c < 4; c++) if (s_credit_o[c]) cnt[c]++;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int c = 0; c < 4; c++) if (s_credit_o[c]) cnt[c]++;
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (cnt[c] !== 2) begin
        errors++;
        $display("FAIL rr credit return ch%0d: got %0d want 2", c, cnt[c]);
      end
    end
    checks++;
    if (m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rr drained: valid=%b want 0", m_valid_o);
    end
  endtask

  task automatic test_lock();
    m_ready_i = 1'b0;
    push(3, 8'hC3);
    tick();
    s_valid_i = '0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) push(0, 8'h0C);
      checks++;
      if (m_valid_o !== 1'b1 || m_id_o !== 2'd3 || m_data_o !== 8'hC3) begin
        errors++;
        $display("FAIL lock hold %0d: valid=%b id=%0d data=%h want 1/3/c3", i, m_valid_o, m_id_o, m_data_o);
      end
      tick();
      s_valid_i = '0;
    end
    m_ready_i = 1'b1;
    checks++;
    if (m_id_o !== 2'd3 || m_data_o !== 8'hC3) begin
      errors++;
      $display("FAIL lock accept ch3: id=%0d data=%h want 3/c3", m_id_o, m_data_o);
    end
    tick();
    checks++;
    if (m_valid_o !== 1'b1 || m_id_o !== 2'd0 || m_data_o !== 8'h0C) begin
      errors++;
      $display("FAIL lock then ch0: valid=%b id=%0d data=%h want 1/0/0c", m_valid_o, m_id_o, m_data_o);
    end
    tick();
    checks++;
    if (m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL lock drained: valid=%b want 0", m_valid_o);
    end
    m_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_overflow();
    logic [7:0] vals[3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    m_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(0, vals[k]);
      tick();
    end
    s_valid_i = '0;
    checks++;
    if (ovf_o !== 4'b0001 || m_id_o !== 2'd0 || m_data_o !== 8'h11) begin
      errors++;
      $display("FAIL ovf set: ovf=%h id=%0d data=%h want 1/0/11", ovf_o, m_id_o, m_data_o);
    end
    tick(); tick();
    m_ready_i = 1'b1;
    checks++;
    if (m_data_o !== 8'h11 || m_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf drain 0: valid=%b data=%h want 1/11", m_valid_o, m_data_o);
    end
    tick();
    checks++;
    if (m_data_o !== 8'h22 || m_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf drain 1: valid=%b data=%h want 1/22", m_valid_o, m_data_o);
    end
    tick();
    checks++;
    if (m_valid_o !== 1'b0 || ovf_o !== 4'b0001) begin
      errors++;
      $display("FAIL ovf after drain: valid=%b ovf=%h want 0/1", m_valid_o, ovf_o);
    end
    m_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_reset_mid();
    m_ready_i = 1'b0;
    push(1, 8'h5A);
    tick();
    push(1, 8'h5B);
    tick();
    s_valid_i = '0;
    checks++;
    if (m_valid_o !== 1'b1 || m_id_o !== 2'd1) begin
      errors++;
      $display("FAIL mid pre-reset: valid=%b id=%0d want 1/1", m_valid_o, m_id_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (m_valid_o !== 1'b0 || ovf_o !== 4'h0) begin
      errors++;
      $display("FAIL mid reset: valid=%b ovf=%h want 0/0", m_valid_o, ovf_o);
    end
    count_credits(6, "mid_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; s_valid_i = '0; s_data_i = '0; m_ready_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
